// File: rtl/dmem_sized_port_pkg.sv
// dmem_sized_port_pkg: shared size/state types and lane helpers for dmem_sized_port (package dmem_pkg)
package dmem_pkg;
  typedef enum logic [1:0] {SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10} size_e;
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  // Lane holding the lowest byte of the access; low bits below the access size are dropped.
  function automatic logic [1:0] eff_lane(logic [1:0] sz, logic [1:0] a);
    return sz == SZ_BYTE ? a : sz == SZ_HALF ? {a[1], 1'b0} : 2'b00;
  endfunction
  // Byte enable for a store; the reserved size code behaves as a word.
  function automatic logic [3:0] lane_mask(logic [1:0] sz, logic [1:0] a);
    return sz == SZ_BYTE ? 4'b0001 << eff_lane(sz, a) :
           sz == SZ_HALF ? 4'b0011 << eff_lane(sz, a) : 4'b1111;
  endfunction
  // Replicate right-justified store data so every enabled lane sees its byte.
  function automatic logic [31:0] lane_data(logic [1:0] sz, logic [31:0] wd);
    return sz == SZ_BYTE ? {4{wd[7:0]}} : sz == SZ_HALF ? {2{wd[15:0]}} : wd;
  endfunction
  function automatic logic misaligned(logic [1:0] sz, logic [1:0] a);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? a[0] : a != 2'b00;
  endfunction
  // Pick the addressed lane(s) from a full word and sign- or zero-extend to 32 bits.
  function automatic logic [31:0] load_ext(logic [1:0] sz, logic [1:0] lane, logic uns, logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    return sz == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
           sz == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : w;
  endfunction
endpackage

// File: rtl/dmem_sized_port_if.sv
// dmem_sized_port_if: valid/ready request and load-response bundle of the sized data memory
interface dmem_sized_port_if #(parameter int ADDR_W = 13);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_lane_ram.sv
// dmem_lane_ram: one byte lane of data memory, synchronous write with enable and registered read
module dmem_lane_ram #(
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);
  logic [7:0] mem [DEPTH];
  // Contents are deliberately not reset; the top clears them with a sweep.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_sized_port.sv
// dmem_sized_port: byte-laned data memory with sized loads/stores and a post-reset clear sweep (optional DMEM_MISALIGN_CHECK_EN)
module dmem_sized_port
  import dmem_pkg::*;
#(
  parameter int DEPTH        = 2048,
  parameter int CLEAR_ON_RST = 1
) (
  input logic           clk,
  input logic           rst,
  dmem_sized_port_if.slave bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int ADDR_W = AW + 2;
  state_e        state, state_n;
  logic [AW-1:0] ctr, ram_addr;
  logic          clear, ready, accept, mis, wr, ld;
  logic [3:0]    be;
  logic [31:0]   wd, rd;
  logic          rsp_v, err_q, r_uns;
  logic [1:0]    r_size, r_lane;
  // State register; reset chooses whether a clear sweep runs first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR_ON_RST != 0 ? ST_CLEAR : ST_RUN;
    else state <= state_n;
  end
  // Sweep ends after the last word has been written; RUN is terminal until reset.
  always_comb begin
    clear   = state == ST_CLEAR;
    ready   = state == ST_RUN;
    state_n = (clear && ctr == AW'(DEPTH - 1)) ? ST_RUN : state;
  end
  // Sweep word counter, restarted from word 0 by every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctr <= '0;
    else if (clear) ctr <= ctr + 1'b1;
  end
  assign accept = bus.req_valid & ready;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign wr       = accept & bus.req_we & ~mis;
  assign ld       = accept & ~bus.req_we;
  assign be       = lane_mask(bus.req_size, bus.req_addr[1:0]);
  assign wd       = lane_data(bus.req_size, bus.req_wdata);
  assign ram_addr = clear ? ctr : bus.req_addr[ADDR_W-1:2];
  for (genvar i = 0; i < 4; i++) begin : g_lane
    dmem_lane_ram #(.DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .we    (clear | (wr & be[i])),
      .addr  (ram_addr),
      .wdata (clear ? 8'h00 : wd[8*i +: 8]),
      .rdata (rd[8*i +: 8])
    );
  end
  // Response pipeline: remember how to extend the load the RAM is reading this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_v  <= 1'b0;
      err_q  <= 1'b0;
      r_size <= 2'b00;
      r_lane <= 2'b00;
      r_uns  <= 1'b0;
    end else begin
      rsp_v <= ld;
      err_q <= accept & mis;
      if (ld) begin
        r_size <= bus.req_size;
        r_lane <= eff_lane(bus.req_size, bus.req_addr[1:0]);
        r_uns  <= bus.req_unsigned;
      end
    end
  end
  assign bus.req_ready = ready;
  assign bus.busy      = clear;
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = (rsp_v & ~err_q) ? load_ext(r_size, r_lane, r_uns, rd) : 32'h0;
endmodule

// File: tb/tb_dmem_sized_port.sv
// tb_dmem_sized_port: directed and random checks of dmem_sized_port against a byte-array model
module tb_dmem_sized_port;
  localparam int DEPTH = 16;
  localparam int AW    = 6;
  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_sized_port_if #(.ADDR_W(AW)) bus();
  dmem_sized_port #(.DEPTH(DEPTH), .CLEAR_ON_RST(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  mm [DEPTH*4];
  logic        exp_v, exp_err;
  logic [31:0] exp_rd;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit mis_m(input logic [1:0] sz, input int a);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (sz == B) return 1'b0;
    if (sz == H) return (a % 2) != 0;
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int nbytes(input logic [1:0] sz);
    return sz == B ? 1 : sz == H ? 2 : 4;
  endfunction
  task automatic clear_model();
    for (int k = 0; k < DEPTH*4; k++) mm[k] = 8'h00;
    exp_v   = 1'b0;
    exp_err = 1'b0;
    exp_rd  = 32'h0;
  endtask
  // One bus cycle: check the response owed by the previous cycle, then issue the next request.
  task automatic op(input bit v, input bit we, input logic [1:0] sz, input bit uns, input int a, input logic [31:0] wd);
    int n, ea;
    logic [31:0] r;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    if (exp_v) chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = AW'(a);
    bus.req_wdata    = wd;
    n       = nbytes(sz);
    ea      = a - (a % n);
    exp_v   = v && !we;
    exp_err = v && mis_m(sz, a);
    exp_rd  = 32'h0;
    if (v && we && !exp_err)
      for (int k = 0; k < n; k++) mm[ea+k] = wd[8*k +: 8];
    if (v && !we && !exp_err) begin
      r = 32'h0;
      for (int k = 0; k < n; k++) r = r | (32'(mm[ea+k]) << (8*k));
      if (!uns && n < 4 && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8*n));
      exp_rd = r;
    end
    @(negedge clk);
  endtask
  task automatic idle();
    op(1'b0, 1'b0, W, 1'b0, 0, 32'h0);
  endtask
  // Expects rst just released at a negedge; sweep must hold busy for exactly DEPTH cycles.
  task automatic sweep_wait();
    for (int i = 0; i < DEPTH; i++) begin
      chk("sweep_busy", 32'(bus.busy), 32'd1);
      chk("sweep_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    chk("run_busy", 32'(bus.busy), 32'd0);
    chk("run_ready", 32'(bus.req_ready), 32'd1);
    clear_model();
  endtask
  task automatic chk_reset_outputs();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
  endtask
  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = W;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = 32'h0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    sweep_wait();
    op(1, 0, W, 0, 'h3C, 0);
    idle();
    op(1, 1, W, 0, 'h8, 32'hDEADBEEF);
    op(1, 0, W, 0, 'h8, 0);
    op(1, 0, B, 1, 'hB, 0);
    op(1, 0, B, 0, 'hB, 0);
    op(1, 1, H, 0, 'hA, 32'h0000_1234);
    op(1, 0, W, 0, 'h8, 0);
    op(1, 0, H, 1, 'hA, 0);
    op(1, 1, B, 0, 'h9, 32'h0000_0077);
    op(1, 0, W, 0, 'h8, 0);
    op(1, 1, W, 0, 'h8, 32'hA5C3_8E71);
    op(1, 0, W, 0, 'h8, 0);
    op(1, 0, B, 0, 'h9, 0);
    op(1, 0, H, 0, 'hA, 0);
    op(1, 0, H, 1, 'h8, 0);
    op(1, 1, W, 0, 'h4, 32'h1122_3344);
    op(1, 0, W, 0, 'h6, 0);
    op(1, 1, H, 0, 'h5, 32'h0000_FFFF);
    op(1, 0, W, 0, 'h4, 0);
    op(1, 0, B, 1, 'h7, 0);
    op(1, 0, 2'b11, 0, 'h4, 0);
    idle();
    for (int i = 0; i < 300; i++)
      op($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, DEPTH*4-1)), $urandom);
    op(1, 1, W, 0, 'h8, 32'hCAFE_F00D);
    op(1, 0, W, 0, 'h8, 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("early_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    sweep_wait();
    for (int w = 0; w < DEPTH; w++) op(1, 0, W, 0, 4*w, 0);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
